// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: decoder-side MUL handshake and result bus
interface mul_sequencer_if #(
    parameter int WIDTH = 8
);
    logic start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic stall;
    logic done;
    logic busy;
    logic [WIDTH-1:0] result;
    modport master (output start, opA, opB, input stall, done, busy, result);
    modport slave (input start, opA, opB, output stall, done, busy, result);
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add multiplier controller that stalls the core while a MUL iterates
module mul_sequencer #(
    parameter int WIDTH = 8,
    parameter int RESULT_HIGH = 1
) (
    input logic clk,
    input logic reset,
    mul_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [1:0] state;
    logic [CW-1:0] count;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0] sum;
    // One shift-add step: add the multiplicand to the accumulator when the multiplier LSB is set
    always_comb sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{prod[0]}}};
    // Capture operands in IDLE, iterate WIDTH steps in RUN, then hand the result over in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            prod <= '0;
            mcand <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mcand <= bus.opA;
                    prod <= {{WIDTH{1'b0}}, bus.opB};
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    prod <= {sum, prod[WIDTH-1:1]};
                    count <= count + 1'b1;
                    state <= count == LAST ? DONE : RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.stall = !reset && ((state == IDLE && bus.start) || state == RUN);
    assign bus.done = state == DONE;
    assign bus.busy = state != IDLE;
    assign bus.result = RESULT_HIGH != 0 ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed MUL vectors checked against a cycle-level product model
module tb_mul_sequencer;
    localparam int W = 8;
    logic clk;
    logic reset;
    logic start;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    mul_sequencer_if #(.WIDTH(W)) ifLo ();
    mul_sequencer_if #(.WIDTH(W)) ifHi ();
    assign ifLo.start = start;
    assign ifLo.opA = opA;
    assign ifLo.opB = opB;
    assign ifHi.start = start;
    assign ifHi.opA = opA;
    assign ifHi.opB = opB;
    mul_sequencer #(.WIDTH(W), .RESULT_HIGH(0)) dutLo (.clk(clk), .reset(reset), .bus(ifLo));
    mul_sequencer #(.WIDTH(W), .RESULT_HIGH(1)) dutHi (.clk(clk), .reset(reset), .bus(ifHi));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Model: phase 0 = no MUL in flight, phase k = k cycles since the capture edge
    int phase = 0;
    bit modelOk = 0;
    bit resValid = 0;
    logic [2*W-1:0] prodExp = '0;
    always @(posedge clk) begin
        if (reset) begin
            phase = 0;
            resValid = 1;
            prodExp = '0;
            modelOk = 1;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                prodExp = (2*W)'(opA) * (2*W)'(opB);
                resValid = 0;
            end
        end else begin
            phase = phase == W + 1 ? 0 : phase + 1;
            if (phase == W + 1) resValid = 1;
        end
    end
    // Per-cycle comparison of both DUT flavours against the model
    always @(negedge clk) begin
        if (modelOk) begin
            check("stallLo", 32'(ifLo.stall), 32'(!reset && ((phase == 0 && start) || (phase >= 1 && phase <= W))));
            check("stallHi", 32'(ifHi.stall), 32'(!reset && ((phase == 0 && start) || (phase >= 1 && phase <= W))));
            check("busy", 32'({ifLo.busy, ifHi.busy}), {30'd0, {2{phase != 0}}});
            check("done", 32'({ifLo.done, ifHi.done}), {30'd0, {2{phase == W + 1}}});
            if (resValid) begin
                check("resultLo", 32'(ifLo.result), 32'(prodExp[W-1:0]));
                check("resultHi", 32'(ifHi.result), 32'(prodExp[2*W-1:W]));
            end
        end
    end
    task automatic runMul(input logic [W-1:0] a, input logic [W-1:0] b, input bit dropMid,
                          output int lat, output int stallCnt, output int doneCyc);
        start = 1;
        opA = a;
        opB = b;
        lat = 0;
        stallCnt = 0;
        #1 if (ifLo.stall) stallCnt++;
        while (!ifLo.done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (dropMid && lat == 3) begin
                start = 0;
                opA = ~a;
                opB = 8'h5A;
            end
            if (ifLo.stall) stallCnt++;
        end
        doneCyc = cyc;
        start = 0;
        @(posedge clk);
        #1;
    endtask
    task automatic mulCheck(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input bit dropMid,
                            input logic [W-1:0] expLo, input logic [W-1:0] expHi, output int doneCyc);
        int lat, stallCnt;
        runMul(a, b, dropMid, lat, stallCnt, doneCyc);
        check({name, ".lat"}, 32'(lat), 32'd9);
        check({name, ".stallCycles"}, 32'(stallCnt), 32'd9);
        check({name, ".lo"}, 32'(ifLo.result), 32'(expLo));
        check({name, ".hi"}, 32'(ifHi.result), 32'(expHi));
    endtask
    initial begin
        int d1, d2, doneSeen;
        reset = 1;
        start = 1;
        opA = 8'hAA;
        opB = 8'h55;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset.flags", 32'({ifLo.stall, ifLo.done, ifLo.busy, ifHi.stall, ifHi.done, ifHi.busy}), 32'd0);
            check("reset.result", 32'({ifLo.result, ifHi.result}), 32'd0);
        end
        start = 0;
        reset = 0;
        @(posedge clk);
        #1;
        mulCheck("m13x11", 8'd13, 8'd11, 0, 8'h8F, 8'h00, d1);
        mulCheck("m255x255", 8'd255, 8'd255, 0, 8'h01, 8'hFE, d1);
        mulCheck("m0x77", 8'd0, 8'd77, 0, 8'h00, 8'h00, d1);
        mulCheck("m77x0", 8'd77, 8'd0, 0, 8'h00, 8'h00, d1);
        mulCheck("m128x2", 8'd128, 8'd2, 0, 8'h00, 8'h01, d1);
        mulCheck("b2b1", 8'd7, 8'd9, 0, 8'd63, 8'd0, d1);
        mulCheck("b2b2", 8'd200, 8'd3, 0, 8'd88, 8'd2, d2);
        check("b2b.spacing", 32'(d2 - d1), 32'd10);
        mulCheck("corrupt", 8'd21, 8'd6, 1, 8'd126, 8'd0, d1);
        start = 1;
        opA = 8'd50;
        opB = 8'd60;
        repeat (4) @(posedge clk);
        #1 reset = 1;
        start = 0;
        @(posedge clk);
        #1;
        check("midReset.flags", 32'({ifLo.stall, ifLo.done, ifLo.busy}), 32'd0);
        reset = 0;
        doneSeen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (ifLo.done || ifHi.done) doneSeen++;
        end
        check("midReset.noDone", 32'(doneSeen), 32'd0);
        mulCheck("afterReset", 8'd100, 8'd100, 0, 8'h10, 8'h27, d1);
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
